// File: rtl/operand_fetch.sv
// operand_fetch: register-file read front end with an in-flight destination scoreboard.
// Optional same-cycle writeback bypass is enabled by defining OPFETCH_BYPASS_EN.
module operand_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_we,
  output logic [ADDR_WIDTH-1:0] r0_addr,
  output logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r0_data,
  input  logic [DATA_WIDTH-1:0] r1_data,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rs1_data,
  output logic [DATA_WIDTH-1:0] out_rs2_data,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_rd_we
);

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0 = '0;

  logic [NREGS-1:0]      busy_r;
  logic [NREGS-1:0]      busy_next_s;
  logic                  out_valid_r;
  logic                  first_r;
  logic                  z1_r;
  logic                  z2_r;
  logic [ADDR_WIDTH-1:0] rd_r;
  logic                  rd_we_r;
  logic [DATA_WIDTH-1:0] hold1_r;
  logic [DATA_WIDTH-1:0] hold2_r;
  logic [DATA_WIDTH-1:0] res1_s;
  logic [DATA_WIDTH-1:0] res2_s;
  logic                  fwd1_s;
  logic                  fwd2_s;
  logic                  fwdd_s;
  logic                  hazard_s;
  logic                  accept_s;
  logic                  set_s;
  logic                  clr_s;

  assign r0_addr = in_rs1;
  assign r1_addr = in_rs2;

`ifdef OPFETCH_BYPASS_EN
  logic                  fwd1_r;
  logic                  fwd2_r;
  logic [DATA_WIDTH-1:0] fwd_data_r;

  assign fwd1_s = wb_en && (wb_addr != X0) && (wb_addr == in_rs1);
  assign fwd2_s = wb_en && (wb_addr != X0) && (wb_addr == in_rs2);
  assign fwdd_s = wb_en && (wb_addr != X0) && (wb_addr == in_rd);

  // Forward flags and data captured at accept; the RF read returns pre-write data in that case.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd1_r     <= 1'b0;
      fwd2_r     <= 1'b0;
      fwd_data_r <= '0;
    end else if (accept_s) begin
      fwd1_r     <= fwd1_s;
      fwd2_r     <= fwd2_s;
      fwd_data_r <= wb_data;
    end
  end

  assign res1_s = z1_r ? '0 : (fwd1_r ? fwd_data_r : r0_data);
  assign res2_s = z2_r ? '0 : (fwd2_r ? fwd_data_r : r1_data);
`else
  logic unused_wb_data_s;

  assign fwd1_s = 1'b0;
  assign fwd2_s = 1'b0;
  assign fwdd_s = 1'b0;
  assign unused_wb_data_s = ^wb_data;
  assign res1_s = z1_r ? '0 : r0_data;
  assign res2_s = z2_r ? '0 : r1_data;
`endif

  assign hazard_s = ((in_rs1 != X0) && busy_r[in_rs1] && !fwd1_s) ||
                    ((in_rs2 != X0) && busy_r[in_rs2] && !fwd2_s) ||
                    (in_rd_we && (in_rd != X0) && busy_r[in_rd] && !fwdd_s);
  assign in_ready = !rst && !hazard_s && (!out_valid_r || out_ready);
  assign accept_s = in_valid && in_ready;
  assign set_s    = accept_s && in_rd_we && (in_rd != X0);
  assign clr_s    = wb_en && (wb_addr != X0);

  // Scoreboard next state: a set on the same index as a clear takes priority.
  always_comb begin
    busy_next_s = '0;
    for (int i = 1; i < NREGS; i++) begin
      busy_next_s[i] = (set_s && (in_rd == ADDR_WIDTH'(i))) ||
                       (busy_r[i] && !(clr_s && (wb_addr == ADDR_WIDTH'(i))));
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Output stage: valid/destination on accept, operands frozen in hold regs after the first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      first_r     <= 1'b0;
      z1_r        <= 1'b0;
      z2_r        <= 1'b0;
      rd_r        <= '0;
      rd_we_r     <= 1'b0;
      hold1_r     <= '0;
      hold2_r     <= '0;
    end else begin
      if (accept_s) begin
        out_valid_r <= 1'b1;
        z1_r        <= (in_rs1 == X0);
        z2_r        <= (in_rs2 == X0);
        rd_r        <= in_rd;
        rd_we_r     <= in_rd_we;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
      first_r <= accept_s;
      if (first_r) begin
        hold1_r <= res1_s;
        hold2_r <= res2_s;
      end
    end
  end

  assign out_valid    = out_valid_r;
  assign out_rs1_data = first_r ? res1_s : hold1_r;
  assign out_rs2_data = first_r ? res2_s : hold2_r;
  assign out_rd       = rd_r;
  assign out_rd_we    = rd_we_r;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: register file model plus an expected-operand scoreboard.
// Expectations follow the OPFETCH_BYPASS_EN setting of the build.
module tb_operand_fetch;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rd_we;
  logic [4:0]  r0_addr, r1_addr;
  logic [31:0] r0_data, r1_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1_data, out_rs2_data;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] rf [32];
  int          compared = 0;
  int          mismatched = 0;
  int          xfers = 0;
  int          mark;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_data(r0_data), .r1_data(r1_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous read returning pre-write data, reloaded on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 7) ? 32'h11 : 32'h1000_0000 + 32'(i);
    end else if (wb_en && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
    r0_data <= rf[r0_addr];
    r1_data <= rf[r1_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_op(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (BYP && wb_en && wb_addr == rs) return wb_data;
    return rf[rs];
  endfunction

  // Scoreboard: push at accept, pop and compare at each output transfer.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        xfers++;
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("sb_rs1", out_rs1_data, e.a);
          check_eq("sb_rs2", out_rs2_data, e.b);
          check_eq("sb_rd", 32'(out_rd), 32'(e.rd));
          check_eq("sb_rd_we", 32'(out_rd_we), 32'(e.we));
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back('{a: exp_op(in_rs1), b: exp_op(in_rs2), rd: in_rd, we: in_rd_we});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic we);
    in_valid = v; in_rs1 = a; in_rs2 = b; in_rd = d; in_rd_we = we;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
    wb(1'b0, 5'd0, 32'd0);
    repeat (3) cyc();
    settle();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_rs1", out_rs1_data, 32'd0);
    check_eq("rst_rs2", out_rs2_data, 32'd0);
    check_eq("rst_rd", 32'(out_rd), 32'd0);
    check_eq("rst_rd_we", 32'(out_rd_we), 32'd0);
    cyc(); rst = 1'b0; drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); settle();
    check_eq("ready_after_rst", 32'(in_ready), 32'd1);

    // x0 operands, rd=3 becomes busy
    cyc(); drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1); settle();
    check_eq("x0_accept", 32'(in_ready), 32'd1);
    cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); settle();
    check_eq("x0_latency", 32'(out_valid), 32'd1);
    check_eq("x0_rd", 32'(out_rd), 32'd3);
    check_eq("x0_rs1", out_rs1_data, 32'd0);
    cyc(); drive(1'b1, 5'd3, 5'd0, 5'd0, 1'b0); settle();
    check_eq("busy3_stall", 32'(in_ready), 32'd0);
    cyc(); wb(1'b1, 5'd3, 32'h33); settle();
    check_eq("busy3_wb", 32'(in_ready), 32'(BYP));
    cyc(); wb(1'b0, 5'd0, 32'd0); settle();
    check_eq("busy3_release", 32'(in_ready), 32'd1);

    // RAW stall on reg 5
    cyc(); drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1); settle();
    check_eq("raw_producer", 32'(in_ready), 32'd1);
    cyc(); drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0); settle();
    check_eq("raw_stall", 32'(in_ready), 32'd0);
    cyc(); settle();
    check_eq("raw_stall2", 32'(in_ready), 32'd0);
    cyc(); wb(1'b1, 5'd5, 32'hDEADBEEF); settle();
    check_eq("raw_wb_cycle", 32'(in_ready), 32'(BYP));
    cyc(); wb(1'b0, 5'd0, 32'd0); settle();
    check_eq("raw_release", 32'(in_ready), 32'd1);
    cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); settle();
    check_eq("raw_operand", out_rs1_data, 32'hDEADBEEF);

    // read during write on reg 7 (not busy)
    cyc(); drive(1'b1, 5'd0, 5'd7, 5'd0, 1'b0); wb(1'b1, 5'd7, 32'h22); settle();
    check_eq("rdw_accept", 32'(in_ready), 32'd1);
    cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); wb(1'b0, 5'd0, 32'd0); settle();
    check_eq("rdw_operand", out_rs2_data, BYP ? 32'h22 : 32'h11);

    // backpressure: sources rewritten while the output is held
    cyc(); drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0); out_ready = 1'b0; settle();
    check_eq("bp_accept", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      cyc(); drive(1'b1, 5'd4, 5'd6, 5'd0, 1'b0);
      wb(1'b1, (k % 2 == 0) ? 5'd1 : 5'd2, 32'hAAAA_0000 + 32'(k)); settle();
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_rs1_held", out_rs1_data, 32'h1000_0001);
      check_eq("bp_rs2_held", out_rs2_data, 32'h1000_0002);
    end
    cyc(); out_ready = 1'b1; wb(1'b0, 5'd0, 32'd0); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); settle();
    check_eq("bp_release_valid", 32'(out_valid), 32'd1);
    check_eq("bp_release_ready", 32'(in_ready), 32'd1);
    mark = xfers;
    cyc(); settle();
    check_eq("bp_drained", 32'(out_valid), 32'd0);
    check_eq("bp_one_xfer", 32'(xfers - mark), 32'd1);

    // scoreboard set/clear collision on reg 9
    cyc(); drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1); wb(1'b1, 5'd9, 32'h99); settle();
    check_eq("col_accept", 32'(in_ready), 32'd1);
    cyc(); drive(1'b1, 5'd9, 5'd0, 5'd0, 1'b0); wb(1'b0, 5'd0, 32'd0); settle();
    check_eq("col_busy", 32'(in_ready), 32'd0);
    cyc(); settle();
    check_eq("col_busy2", 32'(in_ready), 32'd0);
    cyc(); wb(1'b1, 5'd9, 32'h9A); settle();
    check_eq("col_wb", 32'(in_ready), 32'(BYP));
    cyc(); wb(1'b0, 5'd0, 32'd0); settle();
    check_eq("col_release", 32'(in_ready), 32'd1);
    cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); settle();

    // streaming: 10 independent instructions back to back
    for (int i = 0; i < 10; i++) begin
      cyc(); drive(1'b1, 5'(10 + i), 5'(11 + i), 5'(21 + i), 1'b1); settle();
      if (i == 0) mark = xfers;
      check_eq("stream_ready", 32'(in_ready), 32'd1);
      if (i > 0) check_eq("stream_valid", 32'(out_valid), 32'd1);
    end
    cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); settle();
    check_eq("stream_last", 32'(out_valid), 32'd1);
    check_eq("stream_last_rd", 32'(out_rd), 32'd30);
    cyc(); settle();
    check_eq("stream_end", 32'(out_valid), 32'd0);
    check_eq("stream_count", 32'(xfers - mark), 32'd10);

    // reset with a pending output and an in-flight destination
    cyc(); drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b1); settle();
    check_eq("mid_accept", 32'(in_ready), 32'd1);
    cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); out_ready = 1'b0; settle();
    check_eq("mid_pending", 32'(out_valid), 32'd1);
    cyc(); rst = 1'b1; wb(1'b1, 5'd12, 32'h55); settle();
    cyc(); rst = 1'b0; wb(1'b0, 5'd0, 32'd0); out_ready = 1'b1; settle();
    check_eq("rst_drop", 32'(out_valid), 32'd0);
    check_eq("rst_drop_rd", 32'(out_rd), 32'd0);
    cyc(); drive(1'b1, 5'd12, 5'd12, 5'd12, 1'b1); settle();
    check_eq("rst_clear_busy", 32'(in_ready), 32'd1);
    cyc(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0); settle();
    cyc(); settle();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
